// File: rtl/heap_bank_array.sv
// heap_bank_array: BANKS independent 1W1R storage banks behind the heap
// interconnect, with a power-on / soft-clear sweep and fixed read latency.
//
// state  | meaning
// S_INIT | sweeping INIT_VAL into every entry; port traffic dropped, reads forced to 0
// S_RUN  | heap ready; port writes and reads serviced
module heap_bank_array #(
  parameter int                BANKS    = 16,
  parameter int                DATA_W   = 7,
  parameter int                ADDR_W   = 9,
  parameter int                RD_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_clear,
  input  logic [BANKS-1:0]               i_wr_en,
  input  logic [BANKS-1:0][ADDR_W-1:0]   i_wr_addr,
  input  logic [BANKS-1:0][DATA_W-1:0]   i_wr_data,
  input  logic [BANKS-1:0][ADDR_W-1:0]   i_rd_addr,
  output logic [BANKS-1:0][DATA_W-1:0]   o_rd_data,
  output logic                           o_ready
);

  localparam int                 LADDR_W  = ADDR_W - $clog2(BANKS);
  localparam int                 DEPTH    = 2**LADDR_W;
  localparam logic [LADDR_W-1:0] CNT_LAST = LADDR_W'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                        state;
  logic [LADDR_W-1:0]            cnt;
  logic                          live;
  logic [DATA_W-1:0]             mem [BANKS][DEPTH];
  logic [BANKS-1:0][DATA_W-1:0]  rd_val;
  logic [BANKS-1:0][DATA_W-1:0]  rd_q;
  logic                          unused_upper;

  // Upper address bits were already spent on bank select upstream.
  assign unused_upper = ^{i_wr_addr, i_rd_addr};

  // Traffic is honoured only in RUN and not in a cycle that requests a clear.
  assign live = (state == S_RUN) && !i_clear;

  // Sweep FSM: walk cnt through every local index, then hand over to RUN.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= S_INIT;
      cnt     <= '0;
      o_ready <= 1'b0;
    end else if (i_clear) begin
      state   <= S_INIT;
      cnt     <= '0;
      o_ready <= 1'b0;
    end else if (state == S_INIT) begin
      if (cnt == CNT_LAST) begin
        state   <= S_RUN;
        cnt     <= '0;
        o_ready <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Storage: sweep writes all banks in parallel, otherwise independent port writes.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < BANKS; b++) begin
      if (state == S_INIT) begin
        mem[b][cnt] <= INIT_VAL;
      end else if (live && i_wr_en[b]) begin
        mem[b][i_wr_addr[b][LADDR_W-1:0]] <= i_wr_data[b];
      end
    end
  end

  // Read mux with write-first bypass on a local-index match.
  always_comb begin
    rd_val = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (i_wr_en[b] && (i_wr_addr[b][LADDR_W-1:0] == i_rd_addr[b][LADDR_W-1:0])) begin
        rd_val[b] = i_wr_data[b];
      end else begin
        rd_val[b] = mem[b][i_rd_addr[b][LADDR_W-1:0]];
      end
    end
  end

  // First read stage; zeroed whenever the heap is (or is about to be) sweeping.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rd_q <= '0;
    end else if (live) begin
      rd_q <= rd_val;
    end else begin
      rd_q <= '0;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [BANKS-1:0][DATA_W-1:0] rd_q2;

      // Optional output stage, cleared alongside the first so INIT never shows old data.
      always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
          rd_q2 <= '0;
        end else if (live) begin
          rd_q2 <= rd_q;
        end else begin
          rd_q2 <= '0;
        end
      end

      assign o_rd_data = rd_q2;
    end else begin : g_lat1
      assign o_rd_data = rd_q;
    end
  endgenerate

endmodule

// File: doc/heap_bank_array.md
Name: heap_bank_array

Overview:
- Memory-side responder for the heap interconnect: BANKS independent single-write/single-read storage banks.
- Each bank has one write port and one read port, driven from the interconnect's per-bank write/read outputs; read data is returned on the per-bank inputs of the interconnect's read up-tree.
- Owns power-on and soft clear of the whole heap through a sweep state machine.
- Provides fixed read latency so the interconnect pipeline can be balanced against it.

Parameters:
- BANKS, 16, number of banks; must equal 4*CHANS of the interconnect; power of two.
- DATA_W, 7, data width per entry.
- ADDR_W, 9, full heap address width as delivered to each bank.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register).
- INIT_VAL, 0, DATA_W-bit value written to every entry during clear.
- Derived localparam LADDR_W = ADDR_W - $clog2(BANKS) (default 5): bank-local index width; DEPTH = 2**LADDR_W entries per bank.

Ports:
- i_clk  in  1  clock; all state on the rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_clear  in  1  soft-clear request; single-cycle pulse, sampled every cycle.
- i_wr_en  in  BANKS  per-bank write enable.
- i_wr_addr  in  BANKS x ADDR_W  per-bank write address.
- i_wr_data  in  BANKS x DATA_W  per-bank write data.
- i_rd_addr  in  BANKS x ADDR_W  per-bank read address; a read is performed every cycle.
- o_rd_data  out  BANKS x DATA_W  per-bank read data.
- o_ready  out  1  high when the heap is in RUN and accepting traffic.

Behaviour:
- Addressing: each bank uses only the low LADDR_W bits of its addresses. The upper bits are ignored, because the interconnect has already consumed them for bank select.
- Reset (i_rst=0, asynchronous):
  - state=INIT, sweep counter=0, o_ready=0.
  - o_rd_data=0 for every bank, including every read-pipeline stage.
  - Storage contents are undefined until the sweep completes.
- FSM states INIT and RUN:
  - INIT: on each edge, writes INIT_VAL to entry cnt in all banks in parallel, then cnt+1. When the edge writes cnt=DEPTH-1, the next state is RUN and cnt returns to 0.
  - INIT: port writes are dropped; o_rd_data is forced to 0.
  - INIT: i_clear during INIT restarts the sweep at cnt=0.
  - RUN: o_ready=1; port writes and reads are serviced.
  - RUN: i_clear=1 moves to INIT on the next edge (o_ready=0 from that edge). A port write in the same cycle as the clear is dropped.
- Reset timing: after i_rst deasserts, o_ready rises exactly DEPTH edges later (32 by default).
- Counter width is LADDR_W bits with an explicit terminal compare; there is no reliance on wrap-around.
- Write:
  - In RUN with i_wr_en[b]=1 at edge N, mem[b][wr_addr[LADDR_W-1:0]] = wr_data.
  - Banks are fully independent; all BANKS banks may write in the same cycle.
- Read latency:
  - An address presented in the cycle before edge N appears on o_rd_data after edge N+RD_LAT-1.
  - RD_LAT=1: registered read, data visible the cycle after the address.
  - RD_LAT=2: one further register stage.
- Same-cycle collision, same bank: if a write and a read address the same local index in the same cycle, the read returns the new write data (write-first bypass). The bypass uses a comparison of the low bits only.
- Different-address writes and reads in the same bank in the same cycle do not interact.
- Leaving INIT: the first RUN-cycle read returns INIT_VAL, or written data per the bypass rule. The pipeline forcing to 0 releases together with the state change, so no stale INIT zeros appear after o_ready rises except those still in flight in the pipeline.
- Asynchronous reset mid-sweep or mid-traffic: all of the above reset values take effect immediately; the sweep restarts after release.

Test Plan:
- Reset release, idle ports -> o_ready=0 for 32 edges, then 1; reading all 16 banks at every index returns INIT_VAL=0.
- RUN: bank 3 writes 0x55 at addr 0x07C (local 0x1C); next cycle read 0x07C -> o_rd_data[3]=0x55 after RD_LAT cycles; other banks still read 0.
- Same-cycle write 0x2A and read, both at local index 5 of bank 0 -> o_rd_data[0]=0x2A after RD_LAT (bypass); repeat with read index 6 -> returns the old value.
- All 16 banks write distinct values (b+1) to local index 31 in one cycle -> each bank reads back b+1; upper address bits varied -> same result.
- i_clear pulse in RUN with a simultaneous write 0x7F -> o_ready=0 next edge; the write is dropped; after 32 edges o_ready=1 and every entry reads INIT_VAL. A second i_clear at sweep cnt=10 -> o_ready returns only 32 edges after that pulse.
- Drop i_rst at sweep cnt=20 and during RUN traffic -> o_rd_data=0 and o_ready=0 immediately; recovery is identical to the first scenario. Run once with RD_LAT=1 and once with RD_LAT=2, checking the one-cycle latency difference.
